// File: rtl/fifo_wr_arbiter_if.sv
// FIFO write-port bundle between the write arbiter (master) and the FIFO (slave).
interface fifo_wr_arbiter_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] fifo_data_in;
    logic              fifo_wr_en;
    logic              fifo_full;
    logic              fifo_almostfull;
    logic              fifo_wr_ack;
    logic              fifo_overflow;

    modport master (
        output fifo_data_in, fifo_wr_en,
        input  fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow
    );

    modport slave (
        input  fifo_data_in, fifo_wr_en,
        output fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with ack tracking.
// Define FIFO_ARB_STATS_EN to build the per-requester saturating grant counters.
module fifo_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         gnt,
    fifo_wr_arbiter_if.master          wr_port,
    output logic                       busy,
    output logic                       err_overflow,
    output logic                       err_noack,
    output logic [NUM_REQ*CNT_W-1:0]   stat_cnt
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    state_t              state_reg, state_next;
    logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
    logic                wr_en_reg, wr_en_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic                pend_reg;
    logic                err_ovf_reg, err_noack_reg;

    logic [NUM_REQ-1:0]  eligible;
    logic                can_write;
    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W-1:0]    cand_idx;
    logic [DATA_W-1:0]   req_slice [NUM_REQ];

    // The requester granted last cycle may still hold req; mask it so it is not taken twice.
    assign eligible  = req & ~gnt_reg;
    // The in-flight write will consume the last free slot when almostfull is already set.
    assign can_write = !wr_port.fifo_full && !(wr_en_reg && wr_port.fifo_almostfull);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign req_slice[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = PTR_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (!win_found && eligible[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        gnt_next    = '0;
        wr_en_next  = 1'b0;
        data_next   = data_reg;
        case (state_reg)
            HOLD: begin
                if (can_write) begin
                    state_next = win_found ? WRITE : IDLE;
                end
            end
            default: begin
                if (!win_found) begin
                    state_next = IDLE;
                end else if (can_write) begin
                    state_next = WRITE;
                end else begin
                    state_next = HOLD;
                end
            end
        endcase
        if (state_next == WRITE) begin
            gnt_next    = NUM_REQ'(1) << win_idx;
            wr_en_next  = 1'b1;
            data_next   = req_slice[win_idx];
            rr_ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            gnt_reg       <= '0;
            wr_en_reg     <= 1'b0;
            data_reg      <= '0;
            pend_reg      <= 1'b0;
            err_ovf_reg   <= 1'b0;
            err_noack_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            gnt_reg    <= gnt_next;
            wr_en_reg  <= wr_en_next;
            data_reg   <= data_next;
            pend_reg   <= wr_en_reg;
            // pend marks the cycle in which the FIFO answers the previous write.
            if (pend_reg && wr_port.fifo_overflow) begin
                err_ovf_reg <= 1'b1;
            end
            if (pend_reg && !wr_port.fifo_wr_ack && !wr_port.fifo_overflow) begin
                err_noack_reg <= 1'b1;
            end
        end
    end

    assign gnt                  = gnt_reg;
    assign wr_port.fifo_wr_en   = wr_en_reg;
    assign wr_port.fifo_data_in = data_reg;
    assign busy                 = (state_reg != IDLE);
    assign err_overflow         = err_ovf_reg;
    assign err_noack            = err_noack_reg;

`ifdef FIFO_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (gnt_reg[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            assign stat_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter against a behavioural FIFO and reference model.
module tb_fifo_wr_arbiter;
    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int DEPTH = 8;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            busy, err_ovf, err_noack;
    logic [N*CW-1:0] stat_cnt;

    logic rd_en, force_ovf, kill_ack;
    logic env_ack, env_ovf;
    int   fcount;

    int n_vec = 0;
    int n_bad = 0;
    int n_writes;
    logic [N-1:0] last_gnt;

    // reference model state
    logic [N-1:0]  m_gnt;
    logic          m_wr_en, m_busy, m_hold, m_pend, m_eovf, m_enoack;
    logic [DW-1:0] m_data;
    int            m_rr;
    int            m_stat [N];

    fifo_wr_arbiter_if #(.DATA_W(DW)) fif ();

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .wr_port      (fif),
        .busy         (busy),
        .err_overflow (err_ovf),
        .err_noack    (err_noack),
        .stat_cnt     (stat_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO of depth 8: registered ack/overflow, occupancy flags from count.
    assign fif.fifo_full       = (fcount == DEPTH);
    assign fif.fifo_almostfull = (fcount == DEPTH - 1);
    assign fif.fifo_wr_ack     = env_ack && !kill_ack;
    assign fif.fifo_overflow   = env_ovf || force_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcount  <= 0;
            env_ack <= 1'b0;
            env_ovf <= 1'b0;
        end else begin
            env_ack <= fif.fifo_wr_en && !fif.fifo_full;
            env_ovf <= fif.fifo_wr_en && fif.fifo_full;
            fcount  <= fcount + ((fif.fifo_wr_en && !fif.fifo_full) ? 1 : 0)
                              - ((rd_en && fcount != 0) ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gnt = '0; m_wr_en = 1'b0; m_busy = 1'b0; m_hold = 1'b0;
        m_pend = 1'b0; m_eovf = 1'b0; m_enoack = 1'b0; m_data = '0; m_rr = 0;
        for (int i = 0; i < N; i++) m_stat[i] = 0;
    endtask

    // Predicts the outputs after the coming edge from the inputs presented now.
    task automatic predict();
        logic [N-1:0] elig;
        bit space;
        int w;
        elig  = req & ~m_gnt;
        space = !fif.fifo_full && !(m_wr_en && fif.fifo_almostfull);
        if (m_pend && fif.fifo_overflow) m_eovf = 1'b1;
        if (m_pend && !fif.fifo_wr_ack && !fif.fifo_overflow) m_enoack = 1'b1;
        m_pend = m_wr_en;
        for (int i = 0; i < N; i++)
            if (m_gnt[i] && m_stat[i] < (1 << CW) - 1) m_stat[i]++;
        if (elig != 0 && space) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && elig[(m_rr + k) % N]) w = (m_rr + k) % N;
            m_gnt   = N'(1) << w;
            m_wr_en = 1'b1;
            m_data  = req_data[w*DW +: DW];
            m_rr    = (w + 1) % N;
            m_hold  = 1'b0;
            m_busy  = 1'b1;
        end else if (elig != 0 || (m_hold && !space)) begin
            m_gnt = '0; m_wr_en = 1'b0; m_hold = 1'b1; m_busy = 1'b1;
        end else begin
            m_gnt = '0; m_wr_en = 1'b0; m_hold = 1'b0; m_busy = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [N*CW-1:0] exp_stat;
        exp_stat = '0;
`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < N; i++) exp_stat[i*CW +: CW] = CW'(m_stat[i]);
`endif
        check("gnt", gnt, m_gnt);
        check("wr_en", fif.fifo_wr_en, m_wr_en);
        check("busy", busy, m_busy);
        check("err_ovf", err_ovf, m_eovf);
        check("err_noack", err_noack, m_enoack);
        check("stat", stat_cnt, exp_stat);
        if (m_wr_en) check("data", fif.fifo_data_in, m_data);
    endtask

    task automatic cycle();
        #1;
        predict();
        @(posedge clk);
        #1;
        compare_all();
        if (fif.fifo_wr_en) begin
            n_writes++;
            last_gnt = gnt;
        end
    endtask

    // Asserts reset away from any clock edge so the async clear is observed directly.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_gnt", gnt, '0);
        check("rst_wr_en", fif.fifo_wr_en, 1'b0);
        check("rst_data", fif.fifo_data_in, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", {err_ovf, err_noack}, 2'b00);
        check("rst_stat", stat_cnt, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_writes = 0;
    endtask

    initial begin
        logic [N-1:0] exp_seq [5];
        logic [N*CW-1:0] exp_stat;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = '1; rd_en = 1'b1; force_ovf = 1'b0; kill_ack = 1'b0;
        req_data = {$urandom, $urandom};
        n_writes = 0; last_gnt = '0;
        model_reset();
        #2;

        // all four requesting from reset: strict rotation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req_data = {$urandom, $urandom};
            cycle();
            check("t1_seq", gnt, exp_seq[i]);
        end

        // lone requester: one write every two cycles
        req = 4'b0100;
        req_data = '0;
        req_data[2*DW +: DW] = 16'hA5A5;
        for (int i = 0; i < 8; i++) cycle();

        // fill the FIFO from empty, no reads
        do_reset();
        req = 4'b0011; rd_en = 1'b0;
        req_data = {$urandom, $urandom};
        for (int i = 0; i < 24; i++) cycle();
        check("t3_writes", n_writes, 8);
        check("t3_full", fcount, DEPTH);

        // single read frees a slot: exactly one more write, to index 0
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        check("t4_writes", n_writes, 9);
        check("t4_gnt", last_gnt, 4'b0001);

        // forced overflow on the answer cycle of a write
        do_reset();
        rd_en = 1'b1; req = 4'b0001;
        cycle();
        req = '0;
        cycle();
        force_ovf = 1'b1;
        cycle();
        force_ovf = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("t5_eovf", err_ovf, 1'b1);

        // suppressed ack
        do_reset();
        req = 4'b1000;
        cycle();
        req = '0;
        cycle();
        kill_ack = 1'b1;
        cycle();
        kill_ack = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("t5_noack", err_noack, 1'b1);

        // ten grants to requester 1
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 19; i++) begin
            req_data = {$urandom, $urandom};
            cycle();
        end
        req = '0;
        cycle();
        cycle();
        exp_stat = '0;
`ifdef FIFO_ARB_STATS_EN
        exp_stat[1*CW +: CW] = CW'(10);
`endif
        check("t6_stat", stat_cnt, exp_stat);

        // random traffic with varying read pressure, reset hit mid-burst at the end
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req      = N'($urandom);
            req_data = {$urandom, $urandom};
            rd_en    = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                            : ($urandom_range(0, 3) == 0);
            cycle();
        end
        req = '1; rd_en = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        do_reset();
        for (int i = 0; i < 4; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the project FIFO among NUM_REQ producers.
- Sits between the producers and the FIFO DUT-side signals (data_in, wr_en, wr_ack, overflow, full, almostfull).
- Registers the selected word onto the FIFO write port and throttles on full/almostfull so that no write can overflow.
- Tracks wr_ack/overflow for every issued write and flags protocol errors.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, FIFO_WIDTH (shared_pkg, 16), word width.
- CNT_W, 16, width of optional statistics counters.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester write request; held until granted.
- req_data  input  NUM_REQ*DATA_W  flattened data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot, registered; gnt[i]=1 means req_data[i] was taken at the previous edge.
- fifo_data_in  output  DATA_W  registered data to FIFO data_in.
- fifo_wr_en  output  1  registered write enable to FIFO wr_en.
- fifo_full  input  1  FIFO full.
- fifo_almostfull  input  1  FIFO almostfull (count == DEPTH-1).
- fifo_wr_ack  input  1  FIFO wr_ack (registered, one cycle after wr_en).
- fifo_overflow  input  1  FIFO overflow (registered).
- busy  output  1  state != IDLE.
- err_overflow  output  1  sticky; cleared only by reset.
- err_noack  output  1  sticky; an issued write received neither wr_ack nor overflow one cycle later.
- stat_cnt  output  NUM_REQ*CNT_W  optional accepted-write counters (see Optional Feature).

Behaviour:
Reset (async assert, sync release):
- gnt=0, fifo_wr_en=0, fifo_data_in=0, busy=0, err_*=0, stat_cnt=0.
- rr_ptr=0, state=IDLE.

Space rule, evaluated at each edge:
- can_write = !fifo_full && !(fifo_wr_en && fifo_almostfull).
- This covers the write already in flight.

Eligibility:
- eligible = req & ~gnt.
- The requester granted this cycle is masked for one cycle, so a stale held req is never taken twice.
- A lone requester therefore gets at most one write every 2 cycles.

Arbitration:
- Search from rr_ptr upward, wrapping modulo NUM_REQ.
- The first eligible index w wins.
- On a grant, rr_ptr <= (w+1) mod NUM_REQ. The pointer does not move when there is no grant.

States:
- IDLE: no eligible requester.
  - eligible != 0 and can_write -> WRITE.
  - eligible != 0 and !can_write -> HOLD.
- WRITE: a grant is issued at this edge.
  - fifo_wr_en <= 1, fifo_data_in <= req_data[w], gnt <= onehot(w).
  - Next state: WRITE if another eligible requester and can_write; HOLD if eligible but !can_write; else IDLE.
- HOLD: fifo_wr_en <= 0, gnt <= 0.
  - Leave when can_write: -> WRITE if eligible, else IDLE.
- In every non-WRITE transition, gnt and fifo_wr_en are 0 for that cycle.

Latency:
- req rises at edge k with space and no contention -> fifo_wr_en and gnt high in cycle k+1.
- FIFO wr_ack expected in cycle k+2.

Ack tracking:
- pend <= fifo_wr_en.
- If pend and fifo_overflow -> err_overflow <= 1.
- If pend and !fifo_wr_ack and !fifo_overflow -> err_noack <= 1.

Boundaries:
- Simultaneous requests are served in strict rotation from rr_ptr.
- A req that drops before it is granted is simply not selected; no error.
- Reset mid-write clears everything. An in-flight write is not retried.
- fifo_full asserted during HOLD with req pending holds indefinitely; no grant is issued.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - stat_cnt[i] increments by 1 on every cycle gnt[i]=1.
  - Saturates at 2^CNT_W-1; reset to 0.
- Undefined:
  - Counters are not built; stat_cnt tied to 0.
  - All other behaviour is identical.

Test Plan:
1. Reset with req=4'b1111, fifo empty -> after release, gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; fifo_data_in matches each req_data slice; fifo_wr_en continuously 1.
2. Only req[2]=1, data 16'hA5A5 held -> fifo_wr_en pattern 1,0,1,0; gnt=4'b0100 on write cycles.
3. FIFO (DEPTH=8) fills from empty with req=4'b0011, no reads -> exactly 8 writes; busy=1 and fifo_wr_en=0 while full; err_overflow stays 0.
4. Full FIFO in HOLD, one rd_en pulse -> exactly one further write; next grant goes to the index after the last winner.
5. fifo_overflow forced high the cycle after a write -> err_overflow=1 until rst_n=0. Suppressing wr_ack instead -> err_noack=1.
6. With FIFO_ARB_STATS_EN, 10 grants to req[1] -> stat_cnt slice 1 = 10 and the others 0. Assert rst_n=0 mid-burst -> all outputs 0 asynchronously.
